bram_lsu: RTL
=============

# bram_lsu

Load/store unit sitting directly upstream of the core's data BRAM port. It accepts one byte/half/word memory request at a time from the RV32IM execute stage and translates it into BRAM word address, replicated write data and byte-write enables. Load data is aligned and sign- or zero-extended, then returned through a valid/ready response channel. Misaligned, out-of-range and reserved-size requests complete with an error and never touch the BRAM.

## Interface
Parameters:
- DATA_WIDTH, 32, BRAM data width (only 32 supported)
- ADDR_WIDTH, 15, BRAM word-address width
- BASE_ADDR, 32'h0000_0000, byte base of the BRAM window; must be aligned to 2^(ADDR_WIDTH+2)

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, out of range or reserved size
- bram_addr  out  ADDR_WIDTH  word address = req_addr[ADDR_WIDTH+1:2]
- bram_din  out  32  replicated store data
- bram_dout  in  32  BRAM read data
- bram_en  out  1  BRAM enable
- bram_we  out  4  byte write enables
- bram_reset  out  1  equals rst

## Operation
- FSM states: IDLE, RD_WAIT (present only with macro), RD_CAP, RESP.
- req_ready = (state == IDLE) && !rst. Exactly one request is outstanding at a time.
- Accept = req_valid && req_ready. err = misaligned (half with addr[0] set; word with addr[1:0] != 0), or addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2], or size == 3.
- bram_en = accept && !err, driven combinationally in the accept cycle.
- bram_we is nonzero only for a non-error store:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 or 4'b1100 by addr[1]
  - word: 4'b1111
- bram_din: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Transitions:
  - IDLE with store or error → RESP.
  - IDLE with valid load → RD_CAP (or RD_WAIT with macro).
  - RD_WAIT → RD_CAP.
  - RD_CAP → RESP.
  - RESP → IDLE on rsp_ready.
- RD_CAP registers bram_dout >> (8·addr[1:0]), extended from bit 7 or 15 unless req_unsigned. The offset, size and unsigned fields are latched at accept.
- rsp_rdata and rsp_err are held stable while rsp_valid && !rsp_ready.

## Timing
- Accept at cycle N.
- Store or error: rsp_valid at N+1.
- Load: rsp_valid at N+2 without macro, N+3 with macro.
- A response consumed at cycle M gives req_ready = 1 at M+1; back-to-back throughput is one request per 2 cycles for stores, 3 for loads.
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, bram_en 0, bram_we 0, state IDLE.
- Reset mid-load: the in-flight request is dropped with no response, and the BRAM is not re-addressed.
- rsp_ready high in a cycle where rsp_valid is low has no effect.

## Configuration
- BRAM_LSU_DOUT_REG_EN defined: the BRAM has its output register enabled. RD_WAIT is inserted, bram_dout is sampled 2 cycles after accept, and load latency is 3 cycles.
- Not defined: bram_dout is sampled 1 cycle after accept, and load latency is 2 cycles.
- Store and error latency are unchanged in both cases.

## Structure
- bram_lsu_pkg holds:
  - mem_size_e enum (SZ_B, SZ_H, SZ_W, SZ_RSV)
  - lsu_state_e enum
  - byte-enable and replication functions
- Sub-module bram_lsu_fmt: combinational load alignment and extension (dout, offset, size, unsigned → rdata), instantiated in front of the RD_CAP register.

## Test plan
- Word store to addr 0x10, data 0xDEADBEEF: bram_addr = 4, bram_we = 4'hF, rsp_valid at N+1, rsp_err = 0.
- Byte store 0xA5 to addr 0x13: bram_din = 0xA5A5A5A5, bram_we = 4'b1000; a following word load of 0x10 returns 0xA5ADBEEF.
- LB and LBU at addr 0x13 with word 0xA5ADBEEF: rdata 0xFFFFFFA5 and 0x000000A5; LH at 0x12 gives 0xFFFFA5AD. Load latency is 2 cycles, or 3 with the macro.
- LW at 0x12, SH at 0x01, size 3, and addr 0x0002_0000 (ADDR_WIDTH = 15): each gives rsp_err = 1, rdata 0, bram_en never high, rsp_valid at N+1.
- rsp_ready held low for 5 cycles after a load response: rsp_valid and rsp_rdata stable, and req_ready stays 0 throughout.
- rst asserted in RD_CAP: next cycle all outputs are at reset values, and no response emerges after rst deasserts.

Source files
------------

// File: rtl/bram_lsu_pkg.sv
// Shared types and helpers for the BRAM load/store unit: access sizes, FSM states,
// byte-enable generation and store-data replication.
package bram_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_CAP  = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] byte_en(input mem_size_e size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Narrow stores are copied into every lane so the byte enables alone pick the target bytes.
  function automatic logic [31:0] replicate(input mem_size_e size, input logic [31:0] data);
    logic [31:0] rep;
    case (size)
      SZ_B:    rep = {4{data[7:0]}};
      SZ_H:    rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
    return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/bram_lsu_if.sv
// Request/response channel to the execute stage plus the BRAM port of the LSU.
// The slave modport is the LSU; the master modport is its environment (core and BRAM).
interface bram_lsu_if #(
  parameter int ADDR_WIDTH = 15
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [31:0]           bram_din;
  logic [31:0]           bram_dout;
  logic                  bram_en;
  logic [3:0]            bram_we;
  logic                  bram_reset;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, bram_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bram_addr, bram_din, bram_en, bram_we, bram_reset
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, bram_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output bram_addr, bram_din, bram_en, bram_we, bram_reset
  );

endinterface

// File: rtl/bram_lsu_fmt.sv
// Load-data formatter: shifts the addressed byte/half down to bit 0 and sign- or
// zero-extends it to 32 bits.
module bram_lsu_fmt
  import bram_lsu_pkg::*;
(
  input  logic [31:0] dout_i,
  input  logic [1:0]  off_i,
  input  mem_size_e   size_i,
  input  logic        uns_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign shifted = dout_i >> {off_i, 3'b000};

  always_comb begin
    rdata_o = '0;
    case (size_i)
      SZ_B:    rdata_o = {{24{shifted[7] & ~uns_i}}, shifted[7:0]};
      SZ_H:    rdata_o = {{16{shifted[15] & ~uns_i}}, shifted[15:0]};
      SZ_W:    rdata_o = shifted;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/bram_lsu.sv
// Single-outstanding load/store unit in front of a 32-bit data BRAM.
// Define BRAM_LSU_DOUT_REG_EN when the BRAM output register is enabled (adds RD_WAIT).
module bram_lsu
  import bram_lsu_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 15,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  bram_lsu_if.slave  bus
);

  lsu_state_e            state_q, state_d;
  logic [1:0]            off_q, off_d;
  mem_size_e             size_q, size_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  mem_size_e   reqSize;
  logic        reqErr;
  logic        accept;
  logic        bramEn;
  logic [31:0] fmtData;

  assign reqSize = mem_size_e'(bus.req_size);
  assign reqErr  = is_misaligned(reqSize, bus.req_addr[1:0])
                || (bus.req_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2])
                || (reqSize == SZ_RSV);

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign bramEn        = accept && !reqErr;

  // BRAM port is driven straight from the request so the access happens in the accept cycle.
  assign bus.bram_en    = bramEn;
  assign bus.bram_we    = (bramEn && bus.req_we) ? byte_en(reqSize, bus.req_addr[1:0]) : 4'b0000;
  assign bus.bram_addr  = bus.req_addr[ADDR_WIDTH+1:2];
  assign bus.bram_din   = replicate(reqSize, bus.req_wdata);
  assign bus.bram_reset = rst;

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  bram_lsu_fmt u_fmt (
    .dout_i  (bus.bram_dout),
    .off_i   (off_q),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .rdata_o (fmtData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      off_q   <= 2'b00;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Response registers only change on accept and load capture, so they hold while RESP stalls.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          off_d   = bus.req_addr[1:0];
          size_d  = reqSize;
          uns_d   = bus.req_unsigned;
          err_d   = reqErr;
          rdata_d = '0;
          if (bus.req_we || reqErr) begin
            state_d = RESP;
          end else begin
`ifdef BRAM_LSU_DOUT_REG_EN
            state_d = RD_WAIT;
`else
            state_d = RD_CAP;
`endif
          end
        end
      end
      RD_WAIT: state_d = RD_CAP;
      RD_CAP: begin
        rdata_d = fmtData;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
